// File: rtl/pkt_tlp_collector.sv
// -----------------------------------------------------------------------------
// pkt_tlp_collector
//
// Purpose:
//   Sits behind the PCIe packet detector. Every change of the detector's
//   wrapping packet counter marks exactly one new packet. That packet and
//   its type flags are captured in the same cycle. The flags are encoded
//   into a 4-bit type code, and {type, packet} is queued in a FIFO that is
//   drained through a valid/ready port. Per-type, invalid-type and drop
//   statistics are kept in saturating counters and read through a
//   registered select port.
//
// Optional feature:
//   Define PKT_TLP_COLLECTOR_STATS_CLR_EN to add the stats_clr input. It
//   synchronously zeroes all statistics counters and the drop counter, and
//   it wins over any increment in the same cycle. The FIFO and the overflow
//   flag are not affected by it.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   PKT_count    in   detector packet counter (wraps)
//   PKT          in   detector packet contents
//   MRd..Cp1D    in   detector type flags, exactly one expected per packet
//   stat_sel     in   statistics select (0-9 type, 10 invalid, 11 drop)
//   stats_clr    in   statistics clear (only with the macro above)
//   out_valid    out  FIFO head valid
//   out_ready    in   consumer accepts the head
//   out_pkt      out  head packet (0 while empty)
//   out_type     out  head type code (0 while empty, 4'hF = invalid flags)
//   fifo_level   out  occupied FIFO entries
//   overflow     out  sticky; set on the first dropped packet
//   stat_cnt     out  selected counter, one cycle after stat_sel
// -----------------------------------------------------------------------------
module pkt_tlp_collector #(
  parameter int PKT_CNT_WIDTH = 4,
  parameter int OUT_PKT_WIDTH = 160,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PKT_CNT_WIDTH-1:0]         PKT_count,
  input  logic [OUT_PKT_WIDTH-1:0]         PKT,
  input  logic                             MRd,
  input  logic                             MWr,
  input  logic                             IORd,
  input  logic                             IOWr,
  input  logic                             CfgRd0,
  input  logic                             CfgWr0,
  input  logic                             CfgRd1,
  input  logic                             CfgWr1,
  input  logic                             Cpl,
  input  logic                             Cp1D,
  input  logic [3:0]                       stat_sel,
`ifdef PKT_TLP_COLLECTOR_STATS_CLR_EN
  input  logic                             stats_clr,
`endif
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [OUT_PKT_WIDTH-1:0]         out_pkt,
  output logic [3:0]                       out_type,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
  output logic [CNT_WIDTH-1:0]             stat_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 + OUT_PKT_WIDTH;
  localparam int N_TYPES = 10;

  localparam logic [3:0] TYPE_INVALID = 4'hF;

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------
  logic [PKT_CNT_WIDTH-1:0] r_prev_cnt;
  logic                     w_event;

  // Any difference is one packet, the F->0 wrap included. A change seen
  // while reset is high is discarded.
  assign w_event = !reset && (PKT_count != r_prev_cnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation results that disagree with the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) r_prev_cnt <= '0;
    else       r_prev_cnt <= PKT_count;
  end

  // ---------------------------------------------------------------------------
  // Type encoding
  // ---------------------------------------------------------------------------
  logic [N_TYPES-1:0] w_flags;
  logic [3:0]         w_type;
  logic               w_type_valid;

  assign w_flags = {Cp1D, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0,
                    IOWr, IORd, MWr, MRd};

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_type       = TYPE_INVALID;
    w_type_valid = 1'b0;
    if ($onehot(w_flags)) begin
      w_type_valid = 1'b1;
      for (int i = 0; i < N_TYPES; i++) begin
        if (w_flags[i]) w_type = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;

  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = out_valid && out_ready;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;

  // NOTE: the storage array has no reset; pointers and level define what is
  // valid, and the read side masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_type, PKT};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_level != '0);
  assign out_pkt    = out_valid ? w_head[OUT_PKT_WIDTH-1:0] : '0;
  assign out_type   = out_valid ? w_head[ENTRY_W-1 -: 4] : 4'h0;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic w_stats_clr;

`ifdef PKT_TLP_COLLECTOR_STATS_CLR_EN
  assign w_stats_clr = stats_clr;
`else
  assign w_stats_clr = 1'b0;
`endif

  logic [CNT_WIDTH-1:0] r_type_cnt [N_TYPES];
  logic [CNT_WIDTH-1:0] r_inv_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] r_stat_cnt;
  logic [CNT_WIDTH-1:0] w_stat_mux;

  // Counting follows the event, not the push: dropped packets are still
  // counted by type. All counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || w_stats_clr) begin
      for (int i = 0; i < N_TYPES; i++) r_type_cnt[i] <= '0;
      r_inv_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_event) begin
        if (w_type_valid) begin
          for (int i = 0; i < N_TYPES; i++) begin
            if (w_type == 4'(i) && r_type_cnt[i] != '1)
              r_type_cnt[i] <= r_type_cnt[i] + 1'b1;
          end
        end else if (r_inv_cnt != '1) begin
          r_inv_cnt <= r_inv_cnt + 1'b1;
        end
      end
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_comb begin
    w_stat_mux = '0;
    for (int i = 0; i < N_TYPES; i++) begin
      if (stat_sel == 4'(i)) w_stat_mux = r_type_cnt[i];
    end
    if (stat_sel == 4'd10) w_stat_mux = r_inv_cnt;
    if (stat_sel == 4'd11) w_stat_mux = r_drop_cnt;
  end

  // Registered read: shows the counter as it stood before this edge.
  always_ff @(posedge clk) begin
    if (reset) r_stat_cnt <= '0;
    else       r_stat_cnt <= w_stat_mux;
  end

  assign stat_cnt = r_stat_cnt;

endmodule

// File: tb/tb_pkt_tlp_collector.sv
// -----------------------------------------------------------------------------
// tb_pkt_tlp_collector
//
// Self-checking bench for pkt_tlp_collector with default parameters
// (4-bit packet counter, 160-bit packet, 8-entry FIFO, 16-bit counters).
// A table of single-cycle vectors covers push/pop, type encoding and the
// stat port; hand-written sequences cover counter wrap, overflow, full with
// simultaneous pop and push, and reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_pkt_tlp_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   PKT_count;
  logic [159:0] PKT;
  logic         MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, Cp1D;
  logic [3:0]   stat_sel;
  logic         out_ready;
  logic         out_valid;
  logic [159:0] out_pkt;
  logic [3:0]   out_type;
  logic [3:0]   fifo_level;
  logic         overflow;
  logic [15:0]  stat_cnt;
`ifdef PKT_TLP_COLLECTOR_STATS_CLR_EN
  logic         stats_clr = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pkt_tlp_collector dut (
    .clk        (clk),
    .reset      (reset),
    .PKT_count  (PKT_count),
    .PKT        (PKT),
    .MRd        (MRd),
    .MWr        (MWr),
    .IORd       (IORd),
    .IOWr       (IOWr),
    .CfgRd0     (CfgRd0),
    .CfgWr0     (CfgWr0),
    .CfgRd1     (CfgRd1),
    .CfgWr1     (CfgWr1),
    .Cpl        (Cpl),
    .Cp1D       (Cp1D),
    .stat_sel   (stat_sel),
`ifdef PKT_TLP_COLLECTOR_STATS_CLR_EN
    .stats_clr  (stats_clr),
`endif
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pkt    (out_pkt),
    .out_type   (out_type),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .stat_cnt   (stat_cnt)
  );

  // Flag bit order: [0]=MRd ... [9]=Cp1D, matching the type codes 0..9.
  localparam logic [9:0] F_NONE = 10'h000;
  localparam logic [9:0] F_MRD  = 10'h001;
  localparam logic [9:0] F_MWR  = 10'h002;
  localparam logic [9:0] F_IOWR = 10'h008;
  localparam logic [9:0] F_CRD0 = 10'h010;
  localparam logic [9:0] F_CPL  = 10'h100;
  localparam logic [9:0] F_CP1D = 10'h200;

  typedef struct {
    logic [3:0]  cnt;
    logic [9:0]  flags;
    logic [31:0] pkt;
    logic        rdy;
    logic [3:0]  sel;
    logic        e_valid;
    logic [3:0]  e_type;
    logic [31:0] e_pkt;
    logic [3:0]  e_level;
    logic        e_ovf;
    logic [15:0] e_stat;
  } vec_t;

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cnt, input logic [9:0] f,
                       input logic [31:0] pkt);
    PKT_count = cnt;
    PKT       = {128'h0, pkt};
    {Cp1D, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd} = f;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [3:0] t,
                            input logic [31:0] p, input logic [3:0] lvl);
    check({tag, ".valid"}, 160'(out_valid), 160'(v));
    check({tag, ".type"},  160'(out_type),  160'(t));
    check({tag, ".pkt"},   out_pkt,         {128'h0, p});
    check({tag, ".level"}, 160'(fifo_level), 160'(lvl));
  endtask

  vec_t vecs[11];

  initial begin
    vecs = '{
      // cnt   flags          pkt    rdy   sel    valid type   pkt    lvl   ovf   stat
      '{4'd1, F_MWR,         32'hA5, 1'b0, 4'd1,  1'b1, 4'd1,  32'hA5, 4'd1, 1'b0, 16'd0},
      '{4'd1, F_NONE,        32'h00, 1'b0, 4'd1,  1'b1, 4'd1,  32'hA5, 4'd1, 1'b0, 16'd1},
      '{4'd2, F_MRD | F_CPL, 32'hB6, 1'b0, 4'd10, 1'b1, 4'd1,  32'hA5, 4'd2, 1'b0, 16'd0},
      '{4'd3, F_NONE,        32'hC7, 1'b1, 4'd10, 1'b1, 4'hF,  32'hB6, 4'd2, 1'b0, 16'd1},
      '{4'd3, F_NONE,        32'h00, 1'b0, 4'd10, 1'b1, 4'hF,  32'hB6, 4'd2, 1'b0, 16'd2},
      '{4'd4, F_CP1D,        32'hD8, 1'b1, 4'd9,  1'b1, 4'hF,  32'hC7, 4'd2, 1'b0, 16'd0},
      '{4'd4, F_NONE,        32'h00, 1'b1, 4'd9,  1'b1, 4'd9,  32'hD8, 4'd1, 1'b0, 16'd1},
      '{4'd4, F_NONE,        32'h00, 1'b1, 4'd9,  1'b0, 4'd0,  32'h00, 4'd0, 1'b0, 16'd1},
      '{4'd4, F_NONE,        32'h00, 1'b0, 4'd12, 1'b0, 4'd0,  32'h00, 4'd0, 1'b0, 16'd0},
      '{4'd4, F_NONE,        32'h00, 1'b0, 4'd0,  1'b0, 4'd0,  32'h00, 4'd0, 1'b0, 16'd0},
      '{4'd4, F_NONE,        32'h00, 1'b0, 4'd8,  1'b0, 4'd0,  32'h00, 4'd0, 1'b0, 16'd0}
    };

    // Reset
    reset     = 1'b1;
    out_ready = 1'b0;
    stat_sel  = 4'd0;
    drive(4'd0, F_NONE, 32'h0);
    step();
    step();
    check("rst.valid", 160'(out_valid), 160'(0));
    check("rst.level", 160'(fifo_level), 160'(0));
    check("rst.ovf",   160'(overflow), 160'(0));
    check("rst.stat",  160'(stat_cnt), 160'(0));
    check("rst.type",  160'(out_type), 160'(0));
    check("rst.pkt",   out_pkt, 160'(0));
    reset = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].cnt, vecs[i].flags, vecs[i].pkt);
      out_ready = vecs[i].rdy;
      stat_sel  = vecs[i].sel;
      step();
      check_head(tag, vecs[i].e_valid, vecs[i].e_type, vecs[i].e_pkt, vecs[i].e_level);
      check({tag, ".ovf"},  160'(overflow), 160'(vecs[i].e_ovf));
      check({tag, ".stat"}, 160'(stat_cnt), 160'(vecs[i].e_stat));
    end

    // Wrap E->F->0: E carries no flags (invalid), F and 0 carry Cp1D.
    out_ready = 1'b0;
    drive(4'hE, F_NONE, 32'h1); step();
    drive(4'hF, F_CP1D, 32'h2); step();
    drive(4'h0, F_CP1D, 32'h3); step();
    drive(4'h0, F_NONE, 32'h0);
    check_head("wrap.h0", 1'b1, 4'hF, 32'h1, 4'd3);
    out_ready = 1'b1;
    step();
    check_head("wrap.h1", 1'b1, 4'd9, 32'h2, 4'd2);
    step();
    check_head("wrap.h2", 1'b1, 4'd9, 32'h3, 4'd1);
    step();
    out_ready = 1'b0;
    stat_sel  = 4'd9;
    step();
    check("wrap.cnt9", 160'(stat_cnt), 160'(3));
    stat_sel  = 4'd10;
    step();
    check("wrap.inv", 160'(stat_cnt), 160'(3));

    // Overflow: 9 MRd events into an 8-entry FIFO with no draining.
    for (int i = 1; i <= 9; i++) begin
      drive(4'(i), F_MRD, 32'(100 + i - 1));
      step();
      if (i == 8) begin
        check("ovf.level8", 160'(fifo_level), 160'(8));
        check("ovf.notyet", 160'(overflow), 160'(0));
      end
    end
    drive(4'd9, F_NONE, 32'h0);
    check_head("ovf.head", 1'b1, 4'd0, 32'd100, 4'd8);
    check("ovf.flag", 160'(overflow), 160'(1));
    stat_sel = 4'd11;
    step();
    check("ovf.drop", 160'(stat_cnt), 160'(1));
    stat_sel = 4'd0;
    step();
    check("ovf.cnt0", 160'(stat_cnt), 160'(9));

    // Full FIFO with pop and push in the same cycle: no drop.
    drive(4'd10, F_IOWR, 32'd200);
    out_ready = 1'b1;
    step();
    drive(4'd10, F_NONE, 32'h0);
    out_ready = 1'b0;
    check_head("fpp.head", 1'b1, 4'd0, 32'd101, 4'd8);
    check("fpp.ovf", 160'(overflow), 160'(1));
    stat_sel = 4'd11;
    step();
    check("fpp.drop", 160'(stat_cnt), 160'(1));
    stat_sel = 4'd3;
    step();
    check("fpp.cnt3", 160'(stat_cnt), 160'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("drain%0d", i);
      check({tag, ".type"}, 160'(out_type), 160'((i < 7) ? 0 : 3));
      check({tag, ".pkt"},  out_pkt, 160'((i < 7) ? 101 + i : 200));
      step();
    end
    out_ready = 1'b0;
    check("drain.empty", 160'(out_valid), 160'(0));

    // Reset mid-stream with a counter change in the reset cycle.
    for (int i = 0; i < 3; i++) begin
      drive(4'(11 + i), F_CRD0, 32'(300 + i));
      step();
    end
    check_head("pre_rst", 1'b1, 4'd4, 32'd300, 4'd3);
    reset = 1'b1;
    drive(4'd14, F_MWR, 32'hEE);
    step();
    reset = 1'b0;
    drive(4'd0, F_NONE, 32'h0);
    check("mrst.valid", 160'(out_valid), 160'(0));
    check("mrst.level", 160'(fifo_level), 160'(0));
    check("mrst.ovf",   160'(overflow), 160'(0));
    check("mrst.stat",  160'(stat_cnt), 160'(0));
    step();
    check("mrst.noent", 160'(fifo_level), 160'(0));
    for (int i = 0; i < 12; i++) begin
      stat_sel = 4'(i);
      step();
      check($sformatf("mrst.cnt%0d", i), 160'(stat_cnt), 160'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
